// File: rtl/act_unit_sched.sv
// act_unit_sched: issue scheduler in front of a shared softplus/exp unit.
// Two request ports (softplus, exp) are arbitrated round-robin onto one
// registered issue stream. Per-mode credits bound inflight + buffered results
// to FIFO_DEPTH, so a result FIFO can never overflow. A flush drains
// outstanding work without clearing the FIFOs. Results that arrive with nothing
// in flight raise a sticky error and are dropped.
// Optional build macro: ACT_UNIT_SCHED_STATS_EN adds issue/stall counters.
//
// Handshake rule for every stream: a transfer happens on a rising clock edge
// where valid and ready are both high. The source holds valid and data stable
// until that edge. Ready never depends on the same port's valid in the same
// cycle.

// Per-mode result FIFO. The head word is presented as soon as it is stored.
module act_unit_sched_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic          valid,
  output logic [DW-1:0] dout,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;
  logic          do_push;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  // Storage array; contents need no reset because count gates the output.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; push together with pop leaves count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign valid = (count != '0);
  assign dout  = valid ? mem[rd_ptr] : '0;
endmodule

module act_unit_sched #(
  parameter int DW         = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sp_valid_i,
  input  logic [DW-1:0] sp_x_i,
  output logic          sp_ready_o,
  input  logic          ex_valid_i,
  input  logic [DW-1:0] ex_x_i,
  output logic          ex_ready_o,
  output logic          act_valid_o,
  output logic          act_mode_o,
  output logic [DW-1:0] act_x_o,
  input  logic [DW-1:0] act_y_s_i,
  input  logic          act_valid_s_i,
  input  logic [DW-1:0] act_y_e_i,
  input  logic          act_valid_e_i,
  output logic          sp_valid_o,
  output logic [DW-1:0] sp_y_o,
  input  logic          sp_ready_i,
  output logic          ex_valid_o,
  output logic [DW-1:0] ex_y_o,
  input  logic          ex_ready_i,
  input  logic          flush_i,
  output logic          flush_done_o,
  output logic          err_o,
  output logic          dbg_state_o
`ifdef ACT_UNIT_SCHED_STATS_EN
  ,
  output logic [31:0]   stat_sp_issued_o,
  output logic [31:0]   stat_ex_issued_o,
  output logic [31:0]   stat_stall_o
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_S = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          run;
  logic [CW-1:0] infl_sp;
  logic [CW-1:0] infl_ex;
  logic [CW-1:0] cnt_sp;
  logic [CW-1:0] cnt_ex;
  logic          cred_sp;
  logic          cred_ex;
  logic          prio_sp;   // 1: softplus wins the next contested cycle
  logic          acc_sp;
  logic          acc_ex;
  logic          ret_sp;
  logic          ret_ex;
  logic          spur;

  // A mode has credit while inflight plus buffered results leave FIFO room.
  assign cred_sp = ({1'b0, infl_sp} + {1'b0, cnt_sp}) < DEPTH_S;
  assign cred_ex = ({1'b0, infl_ex} + {1'b0, cnt_ex}) < DEPTH_S;

  // Flush FSM: RUN grants, DRAIN waits for all inflight work to return.
  always_comb begin
    state_nxt    = state;
    run          = 1'b0;
    flush_done_o = 1'b0;
    case (state)
      ST_RUN: begin
        run = 1'b1;
        if (flush_i) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((infl_sp == '0) && (infl_ex == '0)) begin
          state_nxt    = ST_RUN;
          flush_done_o = 1'b1;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  assign dbg_state_o = (state == ST_DRAIN);

  // Round-robin ready: a port loses only when the other port is requesting
  // with credit and currently holds priority.
  always_comb begin
    sp_ready_o = !rst && run && cred_sp && (!(ex_valid_i && cred_ex) || prio_sp);
    ex_ready_o = !rst && run && cred_ex && (!(sp_valid_i && cred_sp) || !prio_sp);
  end

  assign acc_sp = sp_valid_i && sp_ready_o;
  assign acc_ex = ex_valid_i && ex_ready_o;
  assign ret_sp = act_valid_s_i && (infl_sp != '0);
  assign ret_ex = act_valid_e_i && (infl_ex != '0);
  assign spur   = (act_valid_s_i && (infl_sp == '0)) ||
                  (act_valid_e_i && (infl_ex == '0));

  // Registered issue stream to the shared unit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_valid_o <= 1'b0;
      act_mode_o  <= 1'b0;
      act_x_o     <= '0;
    end else begin
      act_valid_o <= acc_sp || acc_ex;
      if (acc_sp) begin
        act_mode_o <= 1'b1;
        act_x_o    <= sp_x_i;
      end else if (acc_ex) begin
        act_mode_o <= 1'b0;
        act_x_o    <= ex_x_i;
      end
    end
  end

  // Priority passes to the mode that was not just granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         prio_sp <= 1'b1;
    else if (acc_sp) prio_sp <= 1'b0;
    else if (acc_ex) prio_sp <= 1'b1;
  end

  // Inflight counters: grant adds, matching return removes, both cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      infl_sp <= '0;
      infl_ex <= '0;
    end else begin
      case ({acc_sp, ret_sp})
        2'b10:   infl_sp <= infl_sp + 1'b1;
        2'b01:   infl_sp <= infl_sp - 1'b1;
        default: ;
      endcase
      case ({acc_ex, ret_ex})
        2'b10:   infl_ex <= infl_ex + 1'b1;
        2'b01:   infl_ex <= infl_ex - 1'b1;
        default: ;
      endcase
    end
  end

  // Sticky error on any result that has no matching outstanding request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       err_o <= 1'b0;
    else if (spur) err_o <= 1'b1;
  end

  act_unit_sched_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH), .CW(CW)) u_sp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ret_sp),
    .din   (act_y_s_i),
    .pop   (sp_ready_i),
    .valid (sp_valid_o),
    .dout  (sp_y_o),
    .count (cnt_sp)
  );

  act_unit_sched_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH), .CW(CW)) u_ex_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ret_ex),
    .din   (act_y_e_i),
    .pop   (ex_ready_i),
    .valid (ex_valid_o),
    .dout  (ex_y_o),
    .count (cnt_ex)
  );

`ifdef ACT_UNIT_SCHED_STATS_EN
  logic stall;
  assign stall = (sp_valid_i && !acc_sp) || (ex_valid_i && !acc_ex);

  // Free-running wrap-around statistics; flush leaves them untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_sp_issued_o <= '0;
      stat_ex_issued_o <= '0;
      stat_stall_o     <= '0;
    end else begin
      if (acc_sp) stat_sp_issued_o <= stat_sp_issued_o + 32'd1;
      if (acc_ex) stat_ex_issued_o <= stat_ex_issued_o + 32'd1;
      if (stall)  stat_stall_o     <= stat_stall_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_act_unit_sched.sv
// Testbench for act_unit_sched: request drivers, a latency model of the
// shared unit, and a scoreboard fed with hand-computed expected values.
module tb_act_unit_sched;
  localparam int LAT_SP = 51;
  localparam int LAT_EX = 26;

  logic        clk = 1'b0;
  logic        rst;
  logic        sp_valid_i, ex_valid_i;
  logic [15:0] sp_x_i, ex_x_i;
  logic        sp_ready_o, ex_ready_o;
  logic        act_valid_o, act_mode_o;
  logic [15:0] act_x_o;
  logic [15:0] act_y_s_i, act_y_e_i;
  logic        act_valid_s_i, act_valid_e_i;
  logic        sp_valid_o, ex_valid_o;
  logic [15:0] sp_y_o, ex_y_o;
  logic        sp_ready_i, ex_ready_i;
  logic        flush_i, flush_done_o, err_o, dbg_state_o;
`ifdef ACT_UNIT_SCHED_STATS_EN
  logic [31:0] stat_sp_issued_o, stat_ex_issued_o, stat_stall_o;
`endif

  // ---------------- clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  act_unit_sched #(.DW(16), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .sp_valid_i(sp_valid_i), .sp_x_i(sp_x_i), .sp_ready_o(sp_ready_o),
    .ex_valid_i(ex_valid_i), .ex_x_i(ex_x_i), .ex_ready_o(ex_ready_o),
    .act_valid_o(act_valid_o), .act_mode_o(act_mode_o), .act_x_o(act_x_o),
    .act_y_s_i(act_y_s_i), .act_valid_s_i(act_valid_s_i),
    .act_y_e_i(act_y_e_i), .act_valid_e_i(act_valid_e_i),
    .sp_valid_o(sp_valid_o), .sp_y_o(sp_y_o), .sp_ready_i(sp_ready_i),
    .ex_valid_o(ex_valid_o), .ex_y_o(ex_y_o), .ex_ready_i(ex_ready_i),
    .flush_i(flush_i), .flush_done_o(flush_done_o), .err_o(err_o),
    .dbg_state_o(dbg_state_o)
`ifdef ACT_UNIT_SCHED_STATS_EN
    , .stat_sp_issued_o(stat_sp_issued_o), .stat_ex_issued_o(stat_ex_issued_o),
    .stat_stall_o(stat_stall_o)
`endif
  );

  // ---------------- scoreboard state
  int total = 0;
  int bad = 0;
  logic [16:0] exp_iss_q[$];   // {mode, x}
  logic [15:0] exp_sp_q[$];
  logic [15:0] exp_ex_q[$];
  logic [15:0] sp_req_q[$];
  logic [15:0] ex_req_q[$];
  int          sp_due_q[$], ex_due_q[$];
  logic [15:0] sp_ret_q[$], ex_ret_q[$];
  logic        sp_acc_seen = 1'b0, ex_acc_seen = 1'b0;
  int          n_issue = 0;
  int          sp_iss_cyc = 0, ex_iss_cyc = 0, sp_pop_cyc = 0, ex_pop_cyc = 0;
  int          last_ret_cyc = 0;
  logic        unit_vs = 1'b0, unit_ve = 1'b0, inj_e = 1'b0;
  logic [15:0] unit_ys = '0, unit_ye = '0, inj_y = '0;

  assign act_valid_s_i = unit_vs;
  assign act_y_s_i     = unit_ys;
  assign act_valid_e_i = unit_ve | inj_e;
  assign act_y_e_i     = inj_e ? inj_y : unit_ye;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Shared unit behaviour: known FP16 points, otherwise a fixed bit pattern.
  function automatic logic [15:0] unit_f(input logic m, input logic [15:0] x);
    if (m) begin
      case (x)
        16'h0000: return 16'h398C;  // softplus(0) = ln2
        16'h3C00: return 16'h3D41;  // softplus(1) = 1.3133
        default:  return x ^ 16'h00FF;
      endcase
    end else begin
      case (x)
        16'h0000: return 16'h3C00;  // exp(0) = 1
        16'h3C00: return 16'h4170;  // exp(1) = 2.71828
        default:  return x ^ 16'hFF00;
      endcase
    end
  endfunction

  // ---------------- driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req_sp(input logic [15:0] x, input logic [15:0] y);
    sp_req_q.push_back(x);
    exp_iss_q.push_back({1'b1, x});
    exp_sp_q.push_back(y);
  endtask

  task automatic req_ex(input logic [15:0] x, input logic [15:0] y);
    ex_req_q.push_back(x);
    exp_iss_q.push_back({1'b0, x});
    exp_ex_q.push_back(y);
  endtask

  // Request ports: hold the head operand until it has been accepted.
  initial begin
    sp_valid_i = 1'b0; ex_valid_i = 1'b0; sp_x_i = '0; ex_x_i = '0;
    forever begin
      tick();
      if (sp_acc_seen && sp_req_q.size() > 0) void'(sp_req_q.pop_front());
      if (ex_acc_seen && ex_req_q.size() > 0) void'(ex_req_q.pop_front());
      sp_valid_i = (sp_req_q.size() > 0);
      sp_x_i     = (sp_req_q.size() > 0) ? sp_req_q[0] : 16'h0000;
      ex_valid_i = (ex_req_q.size() > 0);
      ex_x_i     = (ex_req_q.size() > 0) ? ex_req_q[0] : 16'h0000;
    end
  end

  // Unit model: fixed per-mode latency from the issue cycle.
  initial begin
    forever begin
      tick();
      unit_vs = 1'b0;
      unit_ve = 1'b0;
      if (sp_due_q.size() > 0 && sp_due_q[0] == cyc) begin
        void'(sp_due_q.pop_front());
        unit_ys = sp_ret_q.pop_front();
        unit_vs = 1'b1;
        last_ret_cyc = cyc;
      end
      if (ex_due_q.size() > 0 && ex_due_q[0] == cyc) begin
        void'(ex_due_q.pop_front());
        unit_ye = ex_ret_q.pop_front();
        unit_ve = 1'b1;
        last_ret_cyc = cyc;
      end
    end
  end

  // Monitor: samples mid-cycle and checks every issue and result transfer.
  always @(negedge clk) begin
    sp_acc_seen = sp_valid_i && sp_ready_o;
    ex_acc_seen = ex_valid_i && ex_ready_o;
    if (act_valid_o) begin
      n_issue++;
      if (act_mode_o) begin
        sp_iss_cyc = cyc;
        sp_due_q.push_back(cyc + LAT_SP);
        sp_ret_q.push_back(unit_f(1'b1, act_x_o));
      end else begin
        ex_iss_cyc = cyc;
        ex_due_q.push_back(cyc + LAT_EX);
        ex_ret_q.push_back(unit_f(1'b0, act_x_o));
      end
      if (exp_iss_q.size() == 0) begin
        total++; bad++;
        $display("FAIL issue_unexpected: actual mode=%0d x=%h, nothing required", act_mode_o, act_x_o);
      end else begin
        chk("issue_mode_x", {act_mode_o, act_x_o}, exp_iss_q.pop_front());
      end
    end
    if (sp_valid_o && sp_ready_i) begin
      sp_pop_cyc = cyc;
      if (exp_sp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sp_unexpected: actual=%h, nothing required", sp_y_o);
      end else chk("sp_result", sp_y_o, exp_sp_q.pop_front());
    end
    if (ex_valid_o && ex_ready_i) begin
      ex_pop_cyc = cyc;
      if (exp_ex_q.size() == 0) begin
        total++; bad++;
        $display("FAIL ex_unexpected: actual=%h, nothing required", ex_y_o);
      end else chk("ex_result", ex_y_o, exp_ex_q.pop_front());
    end
  end

  task automatic check_rst_outs();
    chk("rst_act", {act_valid_o, act_mode_o, act_x_o}, 32'h0);
    chk("rst_ready", {sp_ready_o, ex_ready_o}, 32'h0);
    chk("rst_sp_out", {sp_valid_o, sp_y_o}, 32'h0);
    chk("rst_ex_out", {ex_valid_o, ex_y_o}, 32'h0);
    chk("rst_flags", {flush_done_o, err_o, dbg_state_o}, 32'h0);
  endtask

  task automatic wait_issues(input int n, input int budget, input string name);
    int k = 0;
    while (n_issue < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, n_issue, n);
  endtask

  task automatic wait_drained(input int budget, input string name);
    int k = 0;
    while ((exp_iss_q.size() + exp_sp_q.size() + exp_ex_q.size()) != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, exp_iss_q.size() + exp_sp_q.size() + exp_ex_q.size(), 0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence
  initial begin
    int base, done_cnt, done_cyc, ret_at_done, gid, rid, k;
    rst = 1'b1; flush_i = 1'b0; sp_ready_i = 1'b1; ex_ready_i = 1'b1;

    // Both ports requesting from reset: alternation must start with softplus.
    req_sp(16'h0000, 16'h398C);
    req_ex(16'h0000, 16'h3C00);
    req_sp(16'h3C00, 16'h3D41);
    req_ex(16'h3C00, 16'h4170);
    req_sp(16'h0011, 16'h00EE);
    req_ex(16'h0022, 16'hFF22);
    exp_iss_q.delete();
    exp_iss_q.push_back({1'b1, 16'h0000});
    exp_iss_q.push_back({1'b0, 16'h0000});
    exp_iss_q.push_back({1'b1, 16'h3C00});
    exp_iss_q.push_back({1'b0, 16'h3C00});
    exp_iss_q.push_back({1'b1, 16'h0011});
    exp_iss_q.push_back({1'b0, 16'h0022});
    repeat (3) begin
      @(negedge clk);
      check_rst_outs();
    end
    tick(); rst = 1'b0;
    @(negedge clk); chk("issue_lat_c0", act_valid_o, 0);
    @(negedge clk); chk("issue_c1_sp", {act_valid_o, act_mode_o}, 2'b11);
    wait_drained(200, "alt_drain");
    chk("alt_issues", n_issue, 6);

    // Credit cap: eight softplus in flight/buffered, sink blocked.
    tick(); sp_ready_i = 1'b0;
    @(negedge clk);
    base = n_issue;
    for (int i = 0; i < 10; i++) req_sp(16'h0100 + 16'(i), 16'h01FF - 16'(i));
    repeat (70) @(negedge clk);
    chk("cap_issues", n_issue - base, 8);
    chk("cap_sp_ready", sp_ready_o, 0);
    chk("cap_sp_valid", sp_valid_o, 1);
    tick(); sp_ready_i = 1'b1;
    tick(); sp_ready_i = 1'b0;
    repeat (10) @(negedge clk);
    chk("pop_one_grant", n_issue - base, 9);
    chk("pop_ready_low", sp_ready_o, 0);
    tick(); sp_ready_i = 1'b1;
    wait_drained(400, "cap_drain");
    chk("cap_total", n_issue - base, 10);

    // Exp overtakes an earlier softplus.
    @(negedge clk); req_sp(16'h3C00, 16'h3D41);
    @(negedge clk); req_ex(16'h0000, 16'h3C00);
    wait_drained(200, "ovt_drain");
    chk("ovt_ex_lat", ex_pop_cyc - ex_iss_cyc, LAT_EX + 1);
    chk("ovt_sp_lat", sp_pop_cyc - sp_iss_cyc, LAT_SP + 1);
    chk("ovt_order", ex_pop_cyc < sp_pop_cyc, 1);

    // Flush with five in flight, sinks blocked so the FIFOs keep results.
    tick(); sp_ready_i = 1'b0; ex_ready_i = 1'b0;
    @(negedge clk);
    base = n_issue;
    req_sp(16'h0301, 16'h03FE);
    req_ex(16'h0401, 16'hFB01);
    req_sp(16'h0302, 16'h03FD);
    req_ex(16'h0402, 16'hFB02);
    req_sp(16'h0303, 16'h03FC);
    exp_iss_q.delete();
    exp_iss_q.push_back({1'b1, 16'h0301});
    exp_iss_q.push_back({1'b0, 16'h0401});
    exp_iss_q.push_back({1'b1, 16'h0302});
    exp_iss_q.push_back({1'b0, 16'h0402});
    exp_iss_q.push_back({1'b1, 16'h0303});
    wait_issues(base + 5, 50, "fl_issues");
    tick(); flush_i = 1'b1;
    @(negedge clk); req_sp(16'h0210, 16'h02EF);
    tick(); flush_i = 1'b0;
    done_cnt = 0; done_cyc = 0; ret_at_done = 0; gid = 0; rid = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (flush_done_o) begin
        done_cnt++;
        done_cyc = cyc;
        ret_at_done = last_ret_cyc;
      end else if (done_cnt == 0) begin
        if (act_valid_o) gid++;
        if (sp_ready_o || ex_ready_o) rid++;
      end
    end
    chk("fl_done_once", done_cnt, 1);
    chk("fl_no_issue", gid, 0);
    chk("fl_no_ready", rid, 0);
    chk("fl_done_cyc", done_cyc, ret_at_done + 1);
    chk("fl_resume_cyc", sp_iss_cyc, done_cyc + 2);
    chk("fl_retained", {sp_valid_o, ex_valid_o}, 2'b11);
    chk("fl_no_err", err_o, 0);
    tick(); sp_ready_i = 1'b1; ex_ready_i = 1'b1;
    wait_drained(200, "fl_drain");

    // Flush with nothing in flight: done pulse on the following cycle only.
    @(negedge clk);
    tick(); flush_i = 1'b1;
    @(negedge clk); chk("zfl_same", flush_done_o, 0);
    tick(); flush_i = 1'b0;
    @(negedge clk); chk("zfl_pulse", flush_done_o, 1);
    @(negedge clk); chk("zfl_after", flush_done_o, 0);

    // Spurious exp result.
    chk("spur_pre", err_o, 0);
    tick(); inj_y = 16'h1234; inj_e = 1'b1;
    tick(); inj_e = 1'b0;
    @(negedge clk);
    chk("spur_err", err_o, 1);
    chk("spur_no_push", ex_valid_o, 0);
    repeat (10) @(negedge clk);
    chk("spur_sticky", err_o, 1);
    chk("spur_still_empty", ex_valid_o, 0);

    // Reset with three softplus in flight; their later returns are spurious.
    @(negedge clk);
    base = n_issue;
    sp_req_q.push_back(16'h0501); exp_iss_q.push_back({1'b1, 16'h0501});
    sp_req_q.push_back(16'h0502); exp_iss_q.push_back({1'b1, 16'h0502});
    sp_req_q.push_back(16'h0503); exp_iss_q.push_back({1'b1, 16'h0503});
    wait_issues(base + 3, 30, "mrst_issues");
    tick(); rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_rst_outs();
    end
    tick(); rst = 1'b0;
    @(negedge clk); chk("mrst_err_clear", err_o, 0);
    k = 0;
    while (!err_o && k < 80) begin
      @(negedge clk);
      k++;
    end
    chk("mrst_late_err", err_o, 1);
    chk("mrst_no_result", sp_valid_o, 0);

    repeat (5) @(negedge clk);
    chk("end_queues", exp_iss_q.size() + exp_sp_q.size() + exp_ex_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
